sample_decimator: RTL and testbench

- Downstream stage of the 2-tap averaging filter; consumes its `o_ce`/`data_out` stream on this block's `i_ce`/`data_in`.
- Keeps every DECIM-th strobed sample and discards the rest.
- Buffers kept samples in a small FIFO.
- Presents them to the next consumer over a valid/ready handshake, decoupling the strobe-driven filter chain from back-pressured downstream logic.

---
 rtl/sample_decimator.sv | 84 ++++++++
 tb/tb_sample_decimator.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sample_decimator.sv
// sample_decimator: keep every DECIM-th strobed sample and buffer it in a FWFT FIFO drained over valid/ready.
// Ports: clk, reset (sync, active-high); i_ce/data_in upstream sample strobe and value;
// o_data/o_valid/i_ready downstream handshake; o_level FIFO occupancy; o_overflow sticky drop flag.
// Optional macro SAMPLE_DECIMATOR_DROP_COUNT_EN adds o_drop_count, a saturating 16-bit count of dropped kept samples.
module sample_decimator #(
    parameter int DATA_WIDTH = 8,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_ce,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow
`ifdef SAMPLE_DECIMATOR_DROP_COUNT_EN
    ,
    output logic [15:0]                   o_drop_count
`endif
);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    logic [PW-1:0]         r_phase;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [LW-1:0]         r_level;
    logic                  w_keep;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    assign w_keep  = i_ce && (r_phase == '0);
    assign w_full  = r_level == LW'(FIFO_DEPTH);
    assign o_valid = r_level != '0;
    assign w_pop   = o_valid && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push  = w_keep && (!w_full || w_pop);
    assign w_drop  = w_keep && w_full && !w_pop;
    assign o_data  = o_valid ? r_mem[r_rd] : '0;
    assign o_level = r_level;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (i_ce)
                r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
            if (w_push) begin
                r_mem[r_wr] <= data_in;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end
`ifdef SAMPLE_DECIMATOR_DROP_COUNT_EN
    logic [15:0] r_drop_count;
    always_ff @(posedge clk) begin
        if (reset)
            r_drop_count <= '0;
        else if (w_drop && r_drop_count != 16'hFFFF)
            r_drop_count <= r_drop_count + 16'd1;
    end
    assign o_drop_count = r_drop_count;
    assign o_overflow   = r_drop_count != '0;
`else
    logic r_overflow;
    always_ff @(posedge clk) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end
    assign o_overflow = r_overflow;
`endif
endmodule

// File: tb/tb_sample_decimator.sv
// tb_sample_decimator: directed self-checking bench for sample_decimator (DECIM=2, FIFO_DEPTH=4).
module tb_sample_decimator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_ce = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic [2:0] o_level;
    logic       o_overflow;
`ifdef SAMPLE_DECIMATOR_DROP_COUNT_EN
    logic [15:0] o_drop_count;
`endif
    int total = 0;
    int bad = 0;
    sample_decimator #(.DATA_WIDTH(8), .DECIM(2), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .i_ce(i_ce),
        .data_in(data_in),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_level(o_level),
        .o_overflow(o_overflow)
`ifdef SAMPLE_DECIMATOR_DROP_COUNT_EN
        ,
        .o_drop_count(o_drop_count)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input logic ce, input int d);
        i_ce = ce;
        data_in = 8'(d);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 77);
        reset = 1'b0;
        check("rst_valid", int'(o_valid), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_level", int'(o_level), 0);
        check("rst_ovf", int'(o_overflow), 0);
    endtask
    int t2_in [6] = '{10, -5, 5, -5, 5, 25};
    int t2_v  [6] = '{1, 0, 1, 0, 1, 0};
    int t2_d  [6] = '{10, 0, 5, 0, 5, 0};
    int t3_ce [5] = '{1, 0, 0, 1, 1};
    int t3_in [5] = '{1, 99, 99, 2, 3};
    int t3_v  [5] = '{1, 0, 0, 0, 1};
    int t3_d  [5] = '{1, 0, 0, 0, 3};
    int drain4 [4] = '{0, 2, 4, 6};
    int drain5 [4] = '{2, 4, 6, 8};
    initial begin
        do_reset();
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, t2_in[i]);
            check("dec_valid", int'(o_valid), t2_v[i]);
            check("dec_data", $signed(o_data), t2_d[i]);
        end
        check("dec_ovf", int'(o_overflow), 0);
        for (int i = 0; i < 5; i++) begin
            step(t3_ce[i][0], t3_in[i]);
            check("gap_valid", int'(o_valid), t3_v[i]);
            check("gap_data", $signed(o_data), t3_d[i]);
        end
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i);
            if (i == 6) begin
                check("bp_level_full", int'(o_level), 4);
                check("bp_ovf_early", int'(o_overflow), 0);
            end
        end
        check("bp_level", int'(o_level), 4);
        check("bp_ovf", int'(o_overflow), 1);
`ifdef SAMPLE_DECIMATOR_DROP_COUNT_EN
        check("bp_drops", int'(o_drop_count), 2);
`endif
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", $signed(o_data), drain4[i]);
            check("drain_level", int'(o_level), 4 - i);
            step(1'b0, 0);
        end
        check("drain_empty", int'(o_valid), 0);
        check("drain_ovf_sticky", int'(o_overflow), 1);
        step(1'b0, 0);
        check("empty_ready_level", int'(o_level), 0);
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, i);
        check("pp_full", int'(o_level), 4);
        i_ready = 1'b1;
        step(1'b1, 8);
        check("pp_level", int'(o_level), 4);
        check("pp_ovf", int'(o_overflow), 0);
        for (int i = 0; i < 4; i++) begin
            check("pp_drain", $signed(o_data), drain5[i]);
            step(1'b0, 0);
        end
        check("pp_empty", int'(o_valid), 0);
        do_reset();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, i);
        check("mid_level", int'(o_level), 3);
        do_reset();
        check("mid_rst_level", int'(o_level), 0);
        step(1'b1, 42);
        check("mid_valid", int'(o_valid), 1);
        check("mid_data", $signed(o_data), 42);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
